controle_jogada: RTL and testbench
==================================

# controle_jogada

Game-input controller sitting directly upstream of the hint-LED stage. It sequences the player's move entry (row → column → value) from a debounced confirm pulse and a 4-bit switch bank. It owns the 81-cell player board and publishes `estadoJogo`, `regLinha`, `regColuna` and `sudokuJogador`, which the hint stage consumes unchanged. After every write it scans the board and enters the end-of-game state once no empty cell remains.

## Interface
Parameters:
- none; board geometry is fixed at 9×9 with 4-bit cells.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `carrega`  in  1  single-cycle pulse; loads a new puzzle from `sudokuInicial`.
- `sudokuInicial`  in  [0:323]  puzzle image; nibble at (l,c) sits at bit (l-1)*36+(c-1)*4, MSB first; 0 = empty.
- `confirma`  in  1  single-cycle debounced button pulse.
- `entrada`  in  4  switch value.
- `desfaz`  in  1  single-cycle undo pulse; present only with `CONTROLE_DESFAZER_EN`.
- `estadoJogo`  out  3  game state code.
- `regLinha`  out  4  selected row, 1..9; 0 = none.
- `regColuna`  out  4  selected column, 1..9; 0 = none.
- `sudokuJogador`  out  [0:323]  current board, same layout as `sudokuInicial`.
- `erro`  out  1  one-cycle pulse on a rejected input.

## Operation
- State codes: recebeLinha 3'b000, recebeColuna 3'b001, verificaFim 3'b010, recebeValor 3'b011, fimJogo 3'b101. Codes 3'b100, 3'b110 and 3'b111 recover to recebeLinha.
- Internal `fixas[0:80]` marks cells that were nonzero at load time. Fixed cells are never written.
- `carrega` (any state, any time): load board from `sudokuInicial`, rebuild `fixas`, clear `regLinha` and `regColuna`, go to recebeLinha.
- recebeLinha, on `confirma`:
  - `entrada` in 1..9: latch into `regLinha`, go to recebeColuna.
  - Otherwise: pulse `erro`, stay.
- recebeColuna, on `confirma`:
  - `entrada` == 4'hF: cancel; clear `regLinha`, go to recebeLinha.
  - `entrada` in 1..9 and the cell is not fixed: latch into `regColuna`, go to recebeValor.
  - Otherwise: pulse `erro`, stay.
- recebeValor, on `confirma`:
  - `entrada` == 4'hF: cancel; clear both registers, go to recebeLinha.
  - `entrada` in 0..9: write the nibble (0 erases), go to verificaFim.
  - 10..14: pulse `erro`, stay.
- verificaFim: scan cell index 0..80, one cell per cycle.
  - On the first zero cell: abort the scan, clear `regLinha` and `regColuna`, go to recebeLinha.
  - If all 81 cells are nonzero: go to fimJogo.
  - `confirma` is ignored in this state.
- fimJogo: terminal. Only `carrega` or reset leaves it.
- Move legality (repeats) is not checked here; the hint stage reports it.
- `carrega` and `confirma` in the same cycle: `carrega` wins and `confirma` is dropped.

## Timing
- Reset values: `estadoJogo` = 3'b000, `regLinha` = 0, `regColuna` = 0, `sudokuJogador` all 0, `fixas` all 0, `erro` = 0, scan index 0.
- All outputs are registered. A `confirma` sampled at edge N is visible on the outputs after edge N.
- `erro` is high for exactly the one cycle after the rejected `confirma`.
- The board write and the entry to verificaFim happen on the same edge.
- Scan latency is 1..81 cycles. A full board reaches fimJogo 81 cycles after the write edge.
- `carrega` during a scan aborts the scan; the load takes effect on the next edge.

## Configuration
- `CONTROLE_DESFAZER_EN` defined:
  - A one-level undo register holds the {cell index, previous nibble, valid} of the last write.
  - `desfaz` in recebeLinha with valid set: restore that nibble, clear valid, return to recebeLinha after one cycle.
  - `desfaz` with valid clear pulses `erro`.
  - `carrega` clears valid.
  - `desfaz` is ignored in states other than recebeLinha.
- Not defined: the `desfaz` port and the undo register are absent; behaviour is otherwise identical.

## Structure
- Shared package:
  - state code localparams;
  - `CELL_W` = 4, `BOARD_W` = 324, `CANCELA` = 4'hF;
  - a cell-offset function (l,c) → bit index.
- The hint stage uses the same state constants.
- One sub-module is natural: `busca_vazia`.
  - Inputs: board and start pulse.
  - Behaviour: 7-bit index counter.
  - Outputs: `achouVazia` or `cheio`, each with a done pulse.

## Test plan
- Reset, then `carrega` of a puzzle with cell (1,1)=5 fixed. Confirm 1, then 1 → `erro` pulses and the state stays 3'b001.
- Confirm 3, 4, 7 on an empty cell (3,4) → bits 84..87 = 4'd7; verificaFim, then recebeLinha; `regLinha` = `regColuna` = 0.
- Load a board with only (9,9) empty. Confirm 9, 9, 2 → fimJogo (3'b101) exactly 81 cycles after the write edge.
- In recebeValor confirm 4'hF → recebeLinha with no board change. In recebeLinha confirm 0 → `erro` pulses.
- Assert `carrega` and `confirma` in the same cycle during verificaFim → board reloaded, state 3'b000, `confirma` ignored.
- With `CONTROLE_DESFAZER_EN` defined: write 6 at (2,2), then `desfaz` → (2,2) returns to 0. A second `desfaz` → `erro` pulses.

Source files
------------

// File: rtl/controle_jogada_pkg.sv
// controle_jogada_pkg: state codes, board geometry and cell addressing shared by
// the move-entry controller and the downstream hint stage.
package controle_jogada_pkg;

  localparam logic [2:0] EST_RECEBE_LINHA  = 3'b000;
  localparam logic [2:0] EST_RECEBE_COLUNA = 3'b001;
  localparam logic [2:0] EST_VERIFICA_FIM  = 3'b010;
  localparam logic [2:0] EST_RECEBE_VALOR  = 3'b011;
  localparam logic [2:0] EST_FIM_JOGO      = 3'b101;

  localparam int         CELL_W    = 4;
  localparam int         BOARD_W   = 324;
  localparam int         N_CELULAS = 81;
  localparam logic [3:0] CANCELA   = 4'hF;

  typedef enum logic [2:0] {
    RECEBE_LINHA  = EST_RECEBE_LINHA,
    RECEBE_COLUNA = EST_RECEBE_COLUNA,
    VERIFICA_FIM  = EST_VERIFICA_FIM,
    RECEBE_VALOR  = EST_RECEBE_VALOR,
    FIM_JOGO      = EST_FIM_JOGO
  } estado_t;

  function automatic logic coord_valida(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd9);
  endfunction

  // Linear cell number 0..80 for a 1-based (row, column) pair.
  function automatic logic [6:0] cell_idx(input logic [3:0] l, input logic [3:0] c);
    return 7'((int'(l) - 1) * 9 + int'(c) - 1);
  endfunction

  // Bit offset of the nibble at (row, column); the nibble's MSB sits at this offset.
  function automatic logic [8:0] cell_off(input logic [3:0] l, input logic [3:0] c);
    return 9'((int'(l) - 1) * 36 + (int'(c) - 1) * CELL_W);
  endfunction

endpackage

// File: rtl/controle_jogada_busca_vazia.sv
// controle_jogada_busca_vazia: after a write, walks the board one cell per cycle
// and reports either the first empty cell or a completely filled board.
module controle_jogada_busca_vazia
  import controle_jogada_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [0:BOARD_W-1] i_tabuleiro,
  input  logic               i_inicia,
  input  logic               i_cancela,
  output logic               o_achou_vazia,
  output logic               o_cheio
);

  logic [6:0] r_idx;
  logic       r_ativo;
  logic [3:0] w_celula;
  logic       w_fim;

  assign w_celula = i_tabuleiro[{r_idx, 2'b00} +: CELL_W];

  // Verdicts are combinational so the controller moves on the same edge the cell is examined.
  assign o_achou_vazia = r_ativo && (w_celula == 4'd0);
  assign o_cheio       = r_ativo && (w_celula != 4'd0) && (r_idx == 7'(N_CELULAS - 1));
  assign w_fim         = o_achou_vazia || o_cheio;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_ativo <= 1'b0;
    end else if (i_cancela) begin
      r_idx   <= '0;
      r_ativo <= 1'b0;
    end else if (i_inicia) begin
      r_idx   <= '0;
      r_ativo <= 1'b1;
    end else if (r_ativo) begin
      if (w_fim) begin
        r_idx   <= '0;
        r_ativo <= 1'b0;
      end else begin
        r_idx <= r_idx + 7'd1;
      end
    end
  end

endmodule

// File: rtl/controle_jogada.sv
// controle_jogada: row/column/value move entry, player board and end-of-game scan.
// Optional one-level undo (desfaz port) when CONTROLE_DESFAZER_EN is defined.
module controle_jogada
  import controle_jogada_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carrega,
  input  logic [0:BOARD_W-1] sudokuInicial,
  input  logic               confirma,
  input  logic [3:0]         entrada,
`ifdef CONTROLE_DESFAZER_EN
  input  logic               desfaz,
`endif
  output logic [2:0]         estadoJogo,
  output logic [3:0]         regLinha,
  output logic [3:0]         regColuna,
  output logic [0:BOARD_W-1] sudokuJogador,
  output logic               erro
);

  estado_t              r_estado, w_prox;
  logic [3:0]           r_linha, r_coluna, w_linha, w_coluna;
  logic [0:BOARD_W-1]   r_tab;
  logic [0:N_CELULAS-1] r_fixas;
  logic                 r_erro, w_erro, w_escreve;
  logic                 w_achou, w_cheio, w_col_livre;
  logic [6:0]           w_idx_col;
  logic [8:0]           w_off_esc;
`ifdef CONTROLE_DESFAZER_EN
  logic [8:0]           r_undo_off;
  logic [3:0]           r_undo_nib;
  logic                 r_undo_val, w_desfaz;
`endif

  assign w_idx_col   = cell_idx(r_linha, entrada);
  assign w_col_livre = coord_valida(entrada) && !r_fixas[w_idx_col];
  assign w_off_esc   = cell_off(r_linha, r_coluna);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_prox    = r_estado;
    w_linha   = r_linha;
    w_coluna  = r_coluna;
    w_erro    = 1'b0;
    w_escreve = 1'b0;
`ifdef CONTROLE_DESFAZER_EN
    w_desfaz  = 1'b0;
`endif
    if (carrega) begin
      w_prox   = RECEBE_LINHA;
      w_linha  = '0;
      w_coluna = '0;
    end else begin
      case (r_estado)
        RECEBE_LINHA: begin
          if (confirma) begin
            if (coord_valida(entrada)) begin
              w_linha = entrada;
              w_prox  = RECEBE_COLUNA;
            end else begin
              w_erro = 1'b1;
            end
          end
`ifdef CONTROLE_DESFAZER_EN
          else if (desfaz) begin
            if (r_undo_val) w_desfaz = 1'b1;
            else            w_erro   = 1'b1;
          end
`endif
        end
        RECEBE_COLUNA: begin
          if (confirma) begin
            if (entrada == CANCELA) begin
              w_linha = '0;
              w_prox  = RECEBE_LINHA;
            end else if (w_col_livre) begin
              w_coluna = entrada;
              w_prox   = RECEBE_VALOR;
            end else begin
              w_erro = 1'b1;
            end
          end
        end
        RECEBE_VALOR: begin
          if (confirma) begin
            if (entrada == CANCELA) begin
              w_linha  = '0;
              w_coluna = '0;
              w_prox   = RECEBE_LINHA;
            end else if (entrada <= 4'd9) begin
              w_escreve = 1'b1;
              w_prox    = VERIFICA_FIM;
            end else begin
              w_erro = 1'b1;
            end
          end
        end
        VERIFICA_FIM: begin
          if (w_achou) begin
            w_linha  = '0;
            w_coluna = '0;
            w_prox   = RECEBE_LINHA;
          end else if (w_cheio) begin
            w_prox = FIM_JOGO;
          end
        end
        FIM_JOGO: w_prox = FIM_JOGO;
        default: begin
          w_linha  = '0;
          w_coluna = '0;
          w_prox   = RECEBE_LINHA;
        end
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= RECEBE_LINHA;
      r_linha  <= '0;
      r_coluna <= '0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_linha  <= w_linha;
      r_coluna <= w_coluna;
      r_erro   <= w_erro;
    end
  end

  // NOTE: the board and fixed mask are reset: the hint stage reads them right out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tab   <= '0;
      r_fixas <= '0;
    end else if (carrega) begin
      r_tab <= sudokuInicial;
      for (int i = 0; i < N_CELULAS; i++) r_fixas[i] <= |sudokuInicial[i*CELL_W +: CELL_W];
    end else if (w_escreve) begin
      r_tab[w_off_esc +: CELL_W] <= entrada;
    end
`ifdef CONTROLE_DESFAZER_EN
    else if (w_desfaz) begin
      r_tab[r_undo_off +: CELL_W] <= r_undo_nib;
    end
`endif
  end

`ifdef CONTROLE_DESFAZER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_undo_off <= '0;
      r_undo_nib <= '0;
      r_undo_val <= 1'b0;
    end else if (carrega) begin
      r_undo_val <= 1'b0;
    end else if (w_escreve) begin
      r_undo_off <= w_off_esc;
      r_undo_nib <= r_tab[w_off_esc +: CELL_W];
      r_undo_val <= 1'b1;
    end else if (w_desfaz) begin
      r_undo_val <= 1'b0;
    end
  end
`endif

  controle_jogada_busca_vazia u_busca_vazia (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tabuleiro   (r_tab),
    .i_inicia      (w_escreve),
    .i_cancela     (carrega),
    .o_achou_vazia (w_achou),
    .o_cheio       (w_cheio)
  );

  assign estadoJogo    = r_estado;
  assign regLinha      = r_linha;
  assign regColuna     = r_coluna;
  assign sudokuJogador = r_tab;
  assign erro          = r_erro;

endmodule

// File: tb/tb_controle_jogada.sv
// tb_controle_jogada: vector table, hand-written timing sequences and a randomized
// run against a cell-array reference model of the move-entry controller.
module tb_controle_jogada;

  localparam int S_LIN = 0, S_COL = 1, S_VER = 2, S_VAL = 3, S_FIM = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         carrega, confirma;
  logic [3:0]   entrada;
  logic [0:323] puz;
  logic [2:0]   estadoJogo;
  logic [3:0]   regLinha, regColuna;
  logic [0:323] sudokuJogador;
  logic         erro;
`ifdef CONTROLE_DESFAZER_EN
  logic         desfaz;
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  controle_jogada dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .carrega       (carrega),
    .sudokuInicial (puz),
    .confirma      (confirma),
    .entrada       (entrada),
`ifdef CONTROLE_DESFAZER_EN
    .desfaz        (desfaz),
`endif
    .estadoJogo    (estadoJogo),
    .regLinha      (regLinha),
    .regColuna     (regColuna),
    .sudokuJogador (sudokuJogador),
    .erro          (erro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esp);
    checks++;
    if (atual !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esp);
    end
  endtask

  task automatic check_tab(input string nome, input logic [0:323] atual, input logic [0:323] esp);
    checks++;
    if (atual !== esp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nome, atual, esp);
    end
  endtask

  function automatic int off(input int l, input int c);
    return (l - 1) * 36 + (c - 1) * 4;
  endfunction

  // Reference model: the board as 81 integers plus a countdown for the end-of-game scan.
  int m_tab[81];
  bit m_fix[81];
  int m_est, m_lin, m_col, m_scan, m_ui, m_un;
  bit m_erro, m_cheio, m_uv;

  task automatic modelo(input bit car, input bit conf, input int ent, input bit dz);
    m_erro = 1'b0;
    if (car) begin
      for (int l = 1; l <= 9; l++)
        for (int c = 1; c <= 9; c++) begin
          m_tab[(l-1)*9 + c-1] = int'(puz[off(l, c) +: 4]);
          m_fix[(l-1)*9 + c-1] = (m_tab[(l-1)*9 + c-1] != 0);
        end
      m_est = S_LIN; m_lin = 0; m_col = 0; m_uv = 1'b0; m_scan = 0;
    end else begin
      case (m_est)
        S_LIN: begin
          if (conf) begin
            if (ent >= 1 && ent <= 9) begin m_lin = ent; m_est = S_COL; end
            else m_erro = 1'b1;
          end else if (UNDO_EN && dz) begin
            if (m_uv) begin m_tab[m_ui] = m_un; m_uv = 1'b0; end
            else m_erro = 1'b1;
          end
        end
        S_COL: begin
          if (conf) begin
            if (ent == 15) begin m_lin = 0; m_est = S_LIN; end
            else if (ent >= 1 && ent <= 9 && !m_fix[(m_lin-1)*9 + ent-1]) begin m_col = ent; m_est = S_VAL; end
            else m_erro = 1'b1;
          end
        end
        S_VAL: begin
          if (conf) begin
            if (ent == 15) begin m_lin = 0; m_col = 0; m_est = S_LIN; end
            else if (ent <= 9) begin
              int k;
              bit achou;
              k = (m_lin-1)*9 + m_col-1;
              m_ui = k; m_un = m_tab[k]; m_uv = 1'b1;
              m_tab[k] = ent;
              m_est = S_VER;
              achou = 1'b0; m_scan = 81;
              for (int i = 0; i < 81; i++)
                if (!achou && m_tab[i] == 0) begin achou = 1'b1; m_scan = i + 1; end
              m_cheio = !achou;
            end else m_erro = 1'b1;
          end
        end
        S_VER: begin
          m_scan--;
          if (m_scan == 0) begin
            if (m_cheio) m_est = S_FIM;
            else begin m_est = S_LIN; m_lin = 0; m_col = 0; end
          end
        end
        default: m_est = m_est;
      endcase
    end
  endtask

  task automatic compara();
    logic [0:323] esp;
    esp = '0;
    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) esp[off(l, c) +: 4] = 4'(m_tab[(l-1)*9 + c-1]);
    check("m_estado", 32'(estadoJogo), 32'(m_est));
    check("m_linha", 32'(regLinha), 32'(m_lin));
    check("m_coluna", 32'(regColuna), 32'(m_col));
    check("m_erro", 32'(erro), 32'(m_erro));
    check_tab("m_tabuleiro", sudokuJogador, esp);
  endtask

  task automatic ciclo(input bit car, input bit conf, input logic [3:0] ent, input bit dz);
    carrega = car; confirma = conf; entrada = ent;
`ifdef CONTROLE_DESFAZER_EN
    desfaz = dz;
`endif
    modelo(car, conf, int'(ent), dz);
    @(posedge clk); #1;
    compara();
  endtask

  function automatic logic [0:323] puz_a();
    logic [0:323] v;
    v = '0;
    v[0 +: 4] = 4'd5;
    return v;
  endfunction

  function automatic logic [0:323] puz_b();
    logic [0:323] v;
    for (int l = 1; l <= 9; l++)
      for (int c = 1; c <= 9; c++) v[off(l, c) +: 4] = 4'(((l-1)*3 + (l-1)/3 + c-1) % 9 + 1);
    v[off(9, 9) +: 4] = 4'd0;
    return v;
  endfunction

  function automatic logic [0:323] puz_aleatorio();
    logic [0:323] v;
    int nv;
    for (int k = 0; k < 81; k++) v[k*4 +: 4] = 4'($urandom_range(1, 9));
    nv = ($urandom_range(0, 3) == 0) ? 30 : int'($urandom_range(1, 4));
    for (int j = 0; j < nv; j++) v[$urandom_range(0, 80)*4 +: 4] = 4'd0;
    return v;
  endfunction

  logic [3:0] tl, tc;

  task automatic escolhe_alvo();
    int q[$];
    int k;
    for (int i = 0; i < 81; i++) if (m_tab[i] == 0) q.push_back(i);
    if (q.size() > 0) begin
      k  = q[$urandom_range(0, q.size() - 1)];
      tl = 4'(k / 9 + 1);
      tc = 4'(k % 9 + 1);
    end else begin
      tl = 4'($urandom_range(1, 9));
      tc = 4'($urandom_range(1, 9));
    end
  endtask

  typedef struct {
    bit         car;
    bit         conf;
    logic [3:0] ent;
    logic [2:0] est;
    logic [3:0] lin;
    logic [3:0] col;
    bit         erro;
  } vetor_t;

  vetor_t vt[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] nib;

    vt[0]  = '{1'b0, 1'b1, 4'h1, 3'd1, 4'd1, 4'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 4'h1, 3'd1, 4'd1, 4'd0, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 4'h0, 3'd1, 4'd1, 4'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 4'hF, 3'd0, 4'd0, 4'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 4'h0, 3'd0, 4'd0, 4'd0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 4'hA, 3'd0, 4'd0, 4'd0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 4'h3, 3'd1, 4'd3, 4'd0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 4'hA, 3'd1, 4'd3, 4'd0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 4'h4, 3'd3, 4'd3, 4'd4, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 4'hC, 3'd3, 4'd3, 4'd4, 1'b1};
    vt[10] = '{1'b0, 1'b1, 4'hF, 3'd0, 4'd0, 4'd0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 4'h3, 3'd1, 4'd3, 4'd0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 4'h4, 3'd3, 4'd3, 4'd4, 1'b0};
    vt[13] = '{1'b0, 1'b1, 4'h7, 3'd2, 4'd3, 4'd4, 1'b0};
    vt[14] = '{1'b0, 1'b1, 4'h2, 3'd2, 4'd3, 4'd4, 1'b0};
    vt[15] = '{1'b0, 1'b0, 4'h0, 3'd0, 4'd0, 4'd0, 1'b0};

    rst_n = 1'b0; carrega = 1'b0; confirma = 1'b0; entrada = 4'd0; puz = '0;
`ifdef CONTROLE_DESFAZER_EN
    desfaz = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_estado", 32'(estadoJogo), 32'd0);
    check("reset_linha", 32'(regLinha), 32'd0);
    check("reset_coluna", 32'(regColuna), 32'd0);
    check("reset_erro", 32'(erro), 32'd0);
    check_tab("reset_tabuleiro", sudokuJogador, '0);

    // Puzzle with only (1,1)=5 fixed, then the vector table.
    puz = puz_a();
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    check_tab("carga_a", sudokuJogador, puz_a());
    for (int i = 0; i < 16; i++) begin
      ciclo(vt[i].car, vt[i].conf, vt[i].ent, 1'b0);
      check($sformatf("vec%0d_estado", i), 32'(estadoJogo), 32'(vt[i].est));
      check($sformatf("vec%0d_linha", i), 32'(regLinha), 32'(vt[i].lin));
      check($sformatf("vec%0d_coluna", i), 32'(regColuna), 32'(vt[i].col));
      check($sformatf("vec%0d_erro", i), 32'(erro), 32'(vt[i].erro));
      if (i == 10) check_tab("cancela_sem_escrita", sudokuJogador, puz_a());
    end
    nib = sudokuJogador[84 +: 4];
    check("celula_3_4", 32'(nib), 32'd7);
    nib = sudokuJogador[0 +: 4];
    check("celula_1_1", 32'(nib), 32'd5);

    // Board with only (9,9) empty: end of game exactly 81 cycles after the write edge.
    puz = puz_b();
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    ciclo(1'b0, 1'b1, 4'd9, 1'b0);
    ciclo(1'b0, 1'b1, 4'd9, 1'b0);
    ciclo(1'b0, 1'b1, 4'd2, 1'b0);
    check("escrita_verifica", 32'(estadoJogo), 32'd2);
    n = 0;
    do begin
      ciclo(1'b0, 1'b0, 4'd0, 1'b0);
      n++;
    end while (estadoJogo != 3'b101 && n < 200);
    check("latencia_fim", 32'(n), 32'd81);
    ciclo(1'b0, 1'b1, 4'd1, 1'b0);
    check("fim_terminal", 32'(estadoJogo), 32'd5);
    check("fim_sem_erro", 32'(erro), 32'd0);

    // carrega and confirma together mid-scan: load wins, scan aborts.
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    check("sai_fim", 32'(estadoJogo), 32'd0);
    ciclo(1'b0, 1'b1, 4'd9, 1'b0);
    ciclo(1'b0, 1'b1, 4'd9, 1'b0);
    ciclo(1'b0, 1'b1, 4'd4, 1'b0);
    repeat (5) ciclo(1'b0, 1'b0, 4'd0, 1'b0);
    check("meio_scan", 32'(estadoJogo), 32'd2);
    puz = puz_a();
    ciclo(1'b1, 1'b1, 4'd9, 1'b0);
    check("abort_estado", 32'(estadoJogo), 32'd0);
    check("abort_linha", 32'(regLinha), 32'd0);
    check_tab("abort_tabuleiro", sudokuJogador, puz_a());
    repeat (90) ciclo(1'b0, 1'b0, 4'd0, 1'b0);
    check("abort_sem_fim", 32'(estadoJogo), 32'd0);

`ifdef CONTROLE_DESFAZER_EN
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    ciclo(1'b0, 1'b1, 4'd2, 1'b0);
    ciclo(1'b0, 1'b1, 4'd2, 1'b0);
    ciclo(1'b0, 1'b1, 4'd6, 1'b0);
    n = 0;
    do begin
      ciclo(1'b0, 1'b0, 4'd0, 1'b0);
      n++;
    end while (estadoJogo != 3'b000 && n < 100);
    nib = sudokuJogador[off(2, 2) +: 4];
    check("undo_escrito", 32'(nib), 32'd6);
    ciclo(1'b0, 1'b0, 4'd0, 1'b1);
    nib = sudokuJogador[off(2, 2) +: 4];
    check("undo_restaurado", 32'(nib), 32'd0);
    check("undo_erro_0", 32'(erro), 32'd0);
    check("undo_estado", 32'(estadoJogo), 32'd0);
    ciclo(1'b0, 1'b0, 4'd0, 1'b1);
    check("undo_vazio_erro", 32'(erro), 32'd1);
`endif

    // Randomized run against the model, biased toward empty cells so games finish.
    puz = puz_aleatorio();
    ciclo(1'b1, 1'b0, 4'd0, 1'b0);
    for (int it = 0; it < 3000; it++) begin
      bit car, conf, dz;
      logic [3:0] ent;
      car  = ($urandom_range(0, 199) == 0);
      if (car) puz = puz_aleatorio();
      conf = 1'($urandom_range(0, 1));
      dz   = UNDO_EN && ($urandom_range(0, 15) == 0);
      ent  = 4'($urandom_range(0, 15));
      if (m_est == S_LIN) escolhe_alvo();
      if ($urandom_range(0, 3) != 0) begin
        case (m_est)
          S_LIN:   ent = tl;
          S_COL:   ent = tc;
          S_VAL:   ent = 4'($urandom_range(1, 9));
          default: ent = ent;
        endcase
      end
      ciclo(car, conf, ent, dz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
